// File: rtl/wtile_burst_loader_if.sv
// Column delivery port and shared W SRAM port of the W tile loader.
// master = loader side, slave = consumer/SRAM side.
interface wtile_burst_loader_if #(
  parameter int M      = 8,
  parameter int DATA_W = 32,
  parameter int K_W    = 10,
  parameter int ROW_W  = 3
) ();
  localparam int BYTE_W = DATA_W / 8;

  logic                  col_valid;
  logic                  col_ready;
  logic [K_W-1:0]        col_k;
  logic [M*DATA_W-1:0]   col_data;

  logic                  w_en;
  logic                  w_re;
  logic                  w_we;
  logic [ROW_W-1:0]      w_row;
  logic [K_W-1:0]        w_k;
  logic [DATA_W-1:0]     w_wdata;
  logic [BYTE_W-1:0]     w_wmask;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_rvalid;

  modport master (
    output col_valid, col_k, col_data,
    input  col_ready,
    output w_en, w_re, w_we, w_row, w_k,
    output w_wdata, w_wmask,
    input  w_rdata, w_rvalid
  );

  modport slave (
    input  col_valid, col_k, col_data,
    output col_ready,
    input  w_en, w_re, w_we, w_row, w_k,
    input  w_wdata, w_wmask,
    output w_rdata, w_rvalid
  );
endinterface

// File: rtl/wtile_burst_loader.sv
// Multi-column W loader: streams k columns out of the W SRAM through
// two ping-pong column banks, yielding the SRAM port to CPU writes.
module wtile_burst_loader #(
  parameter int M      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  localparam int BYTE_W = DATA_W / 8,
  localparam int ROW_W  = (M > 1) ? $clog2(M) : 1,
  localparam int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1,
  localparam int CNT_W  = $clog2(KMAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [K_W-1:0]    k_base_i,
  input  logic [CNT_W-1:0]  k_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              cpu_w_we_i,
  input  logic [ROW_W-1:0]  cpu_w_row_i,
  input  logic [K_W-1:0]    cpu_w_k_i,
  input  logic [DATA_W-1:0] cpu_w_wdata_i,
  input  logic [BYTE_W-1:0] cpu_w_wmask_i,
  wtile_burst_loader_if.master bus
);

  localparam int IW = $clog2(4 * M + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    B_FREE, B_FILL, B_FULL
  } bank_e;

  state_e state_q, state_d;

  bank_e             bst_q  [2];
  logic [DATA_W-1:0] bdat_q [2][M];
  logic [K_W-1:0]    bk_q   [2];

  logic              iss_bank_q;
  logic              ret_bank_q;
  logic              pres_q;
  logic [ROW_W-1:0]  iss_row_q;
  logic [ROW_W-1:0]  ret_row_q;
  logic [K_W-1:0]    iss_k_q;
  logic [CNT_W-1:0]  iss_left_q;
  logic [CNT_W-1:0]  acc_left_q;
  logic [IW-1:0]     infl_q;
  logic [IW-1:0]     drop_q;
  logic              err_q;

  logic [CNT_W:0]    end_k;
  logic [IW-1:0]     flight_tot;
  logic [IW-1:0]     flight_rst;
  logic              range_bad;
  logic              start_ok;
  logic              iss_free;
  logic              iss_last;
  logic              ret_last;
  logic              issue;
  logic              col_vld;
  logic              acc;
  logic              beat;

  assign end_k     = (CNT_W+1)'(k_base_i)
                   + (CNT_W+1)'(k_count_i);
  assign range_bad = end_k > (CNT_W+1)'(KMAX);
  assign start_ok  = start_i && !range_bad;

  // Row 0 claims a bank; later rows continue the column already claimed.
  assign iss_free  = (iss_row_q != '0)
                   || (bst_q[iss_bank_q] == B_FREE);
  assign iss_last  = iss_row_q == ROW_W'(M - 1);
  assign ret_last  = ret_row_q == ROW_W'(M - 1);

  assign col_vld   = bst_q[pres_q] == B_FULL;
  assign acc       = col_vld && bus.col_ready;
  assign beat      = bus.w_rvalid && (drop_q == '0);

  // Reads still outstanding when rst hits are discarded on return.
  assign flight_tot = drop_q + infl_q;
  assign flight_rst = flight_tot
    - IW'(bus.w_rvalid && (flight_tot != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = (k_count_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue && iss_last
            && iss_left_q == CNT_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (acc && acc_left_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = state_q != S_IDLE;
    done_o = state_q == S_DONE;
    issue  = !rst && (state_q == S_FETCH)
           && !cpu_w_we_i && iss_free;
  end

  assign err_o = err_q;

  always_comb begin
    bus.w_en    = issue;
    bus.w_re    = issue;
    bus.w_we    = 1'b0;
    bus.w_row   = issue ? iss_row_q : '0;
    bus.w_k     = issue ? iss_k_q : '0;
    bus.w_wdata = '0;
    bus.w_wmask = '0;
    if (cpu_w_we_i) begin
      bus.w_en    = 1'b1;
      bus.w_re    = 1'b0;
      bus.w_we    = 1'b1;
      bus.w_row   = cpu_w_row_i;
      bus.w_k     = cpu_w_k_i;
      bus.w_wdata = cpu_w_wdata_i;
      bus.w_wmask = cpu_w_wmask_i;
    end
  end

  assign bus.col_valid = col_vld;
  assign bus.col_k     = bk_q[pres_q];

  for (genvar g = 0; g < M; g++) begin : g_col
    assign bus.col_data[g*DATA_W +: DATA_W] =
      bdat_q[pres_q][g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bst_q      <= '{default: B_FREE};
      bdat_q     <= '{default: '0};
      bk_q       <= '{default: '0};
      iss_bank_q <= 1'b0;
      ret_bank_q <= 1'b0;
      pres_q     <= 1'b0;
      iss_row_q  <= '0;
      ret_row_q  <= '0;
      iss_k_q    <= '0;
      iss_left_q <= '0;
      acc_left_q <= '0;
      infl_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= flight_rst;
    end else begin
      err_q <= (state_q == S_IDLE) && start_i && range_bad;

      if (state_q == S_IDLE && start_ok) begin
        iss_k_q    <= k_base_i;
        iss_left_q <= k_count_i;
        acc_left_q <= k_count_i;
        iss_row_q  <= '0;
      end

      if (issue) begin
        if (iss_row_q == '0) begin
          bk_q[iss_bank_q]  <= iss_k_q;
          bst_q[iss_bank_q] <= B_FILL;
        end
        if (iss_last) begin
          iss_row_q  <= '0;
          iss_bank_q <= ~iss_bank_q;
          iss_k_q    <= iss_k_q + K_W'(1);
          iss_left_q <= iss_left_q - CNT_W'(1);
        end else begin
          iss_row_q <= iss_row_q + ROW_W'(1);
        end
      end

      if (beat) begin
        bdat_q[ret_bank_q][ret_row_q] <= bus.w_rdata;
        if (ret_last) begin
          ret_row_q         <= '0;
          ret_bank_q        <= ~ret_bank_q;
          bst_q[ret_bank_q] <= B_FULL;
        end else begin
          ret_row_q <= ret_row_q + ROW_W'(1);
        end
      end

      if (acc) begin
        bst_q[pres_q] <= B_FREE;
        pres_q        <= ~pres_q;
        acc_left_q    <= acc_left_q - CNT_W'(1);
      end

      infl_q <= infl_q + IW'(issue) - IW'(beat);
      if (bus.w_rvalid && drop_q != '0) begin
        drop_q <= drop_q - IW'(1);
      end
    end
  end

endmodule
